// File: rtl/game_state_ctrl_pkg.sv
// Shared game definitions: screen state encoding and counter widths,
// used by the state controller, the display and the sprite blocks.
package game_state_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_TITLE  = 2'd0,
      ST_PLAY   = 2'd1,
      ST_OVER   = 2'd2,
      ST_ENDING = 2'd3
   } game_state_e;

   localparam int DEB_W   = 4;
   localparam int HOLD_W  = 8;
   localparam int BLINK_W = 8;

   // OVER and ENDING share the minimum-hold behaviour before restart.
   function automatic logic is_hold_state(input game_state_e s);
      return (s == ST_OVER) || (s == ST_ENDING);
   endfunction

endpackage

// File: rtl/game_state_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, frame-based debounce
// counter and a single-cycle press pulse on acceptance.
module btn_debounce
   import game_state_ctrl_pkg::*;
#(
   parameter int DEB_FRAMES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_tick,
   input  logic btn_in,
   output logic press_pulse
);

   localparam logic [DEB_W-1:0] C_DEB = DEB_W'(DEB_FRAMES);

   logic             r_sync1;
   logic             r_sync2;
   logic [DEB_W-1:0] r_cnt;
   logic             r_ok_d;
   logic             w_btn_ok;

   // Bring the asynchronous button level into the clk domain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
      end
   end

   // Count stable-high frames, saturating; any low sample restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (!r_sync2) begin
         r_cnt <= '0;
      end else if (frame_tick && (r_cnt != C_DEB)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_btn_ok = (r_cnt == C_DEB);

   // Delay btn_ok by one cycle so a held button yields a single pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_ok_d <= 1'b0;
      else      r_ok_d <= w_btn_ok;
   end

   assign press_pulse = w_btn_ok & ~r_ok_d;

endmodule

// File: rtl/game_state_ctrl.sv
// Game screen sequencer: TITLE/PLAY/OVER/ENDING, restart hold timer and
// title-screen blink.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_TITLE  | attract screen, blink running, waits for start
//   ST_PLAY   | game running, waits for game_over / ending
//   ST_OVER   | dead screen, start accepted once hold elapsed
//   ST_ENDING | score-99 screen, start accepted once hold elapsed
module game_state_ctrl
   import game_state_ctrl_pkg::*;
#(
   parameter int DEB_FRAMES   = 4,
   parameter int HOLD_FRAMES  = 120,
   parameter int BLINK_FRAMES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       game_over,
   input  logic       ending,
   output logic       game_st,
   output logic [1:0] state,
   output logic       new_game,
   output logic       blink
);

   localparam logic [HOLD_W-1:0]  C_HOLD      = HOLD_W'(HOLD_FRAMES);
   localparam logic [BLINK_W-1:0] C_BLINK_TOP = BLINK_W'(BLINK_FRAMES - 1);

   game_state_e        r_state;
   game_state_e        w_state_nxt;
   logic               w_start_pulse;
   logic               w_hold_done;
   logic               w_new_game_nxt;
   logic               w_game_st_nxt;
   logic               r_new_game;
   logic               r_game_st;
   logic [HOLD_W-1:0]  r_hold_cnt;
   logic [BLINK_W-1:0] r_blink_cnt;
   logic               r_blink;

   btn_debounce #(
      .DEB_FRAMES (DEB_FRAMES)
   ) u_start_deb (
      .clk         (clk),
      .rst         (rst),
      .frame_tick  (frame_tick),
      .btn_in      (start_btn),
      .press_pulse (w_start_pulse)
   );

   assign w_hold_done = (r_hold_cnt == C_HOLD);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_TITLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state decode; game_over has priority over ending.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_TITLE:  if (w_start_pulse) w_state_nxt = ST_PLAY;
         ST_PLAY: begin
            if (game_over)   w_state_nxt = ST_OVER;
            else if (ending) w_state_nxt = ST_ENDING;
         end
         ST_OVER,
         ST_ENDING: if (w_start_pulse && w_hold_done) w_state_nxt = ST_PLAY;
         default:   w_state_nxt = ST_TITLE;
      endcase
   end

   // Output decode from the upcoming state so flags line up with it.
   always_comb begin
      w_game_st_nxt  = (w_state_nxt == ST_PLAY);
      w_new_game_nxt = (r_state != ST_PLAY) && (w_state_nxt == ST_PLAY);
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_new_game <= 1'b0;
         r_game_st  <= 1'b0;
      end else begin
         r_new_game <= w_new_game_nxt;
         r_game_st  <= w_game_st_nxt;
      end
   end

   // Hold timer: held at zero outside OVER/ENDING, so each entry starts fresh.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold_cnt <= '0;
      end else if (!is_hold_state(r_state)) begin
         r_hold_cnt <= '0;
      end else if (frame_tick && !w_hold_done) begin
         r_hold_cnt <= r_hold_cnt + 1'b1;
      end
   end

   // Title blink: toggles every BLINK_FRAMES frames, forced on elsewhere.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b1;
      end else if (w_state_nxt != ST_TITLE) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b1;
      end else if (frame_tick) begin
         if (r_blink_cnt == C_BLINK_TOP) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

   assign state    = r_state;
   assign game_st  = r_game_st;
   assign new_game = r_new_game;
   assign blink    = r_blink;

endmodule
